// File: rtl/blocking_seq_ctrl_if.sv
// Handshake and register bus for the blocking_seq_ctrl sequencer.
// The master drives the run controls and init values; the slave returns the registers and status.
interface blocking_seq_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int ITER  = 4
);
  localparam int ICW = $clog2(ITER + 1);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] init_a;
  logic [WIDTH-1:0] init_b;
  logic [WIDTH-1:0] init_c;
  logic [WIDTH-1:0] init_d;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             busy;
  logic             done;
  logic [1:0]       step;
  logic [ICW-1:0]   iter_cnt;

  modport master (
    output start, abort, init_a, init_b, init_c, init_d,
    input  a, b, c, d, busy, done, step, iter_cnt
  );

  modport slave (
    input  start, abort, init_a, init_b, init_c, init_d,
    output a, b, c, d, busy, done, step, iter_cnt
  );
endinterface

// File: rtl/blocking_seq_ctrl.sv
// Clocked sequencer for the chain a=b+c, d=a-3, b=d+10, c=c+1.
// Each update waits out a STEP_CYCLES timer; the four-step chain repeats ITER times.
module blocking_seq_ctrl #(
  parameter int WIDTH       = 32,
  parameter int ITER        = 4,
  parameter int STEP_CYCLES = 5
) (
  input  logic               clk,
  input  logic               rst,
  blocking_seq_ctrl_if.slave bus
);
  localparam int ICW = $clog2(ITER + 1);
  localparam int TW  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0]  TIMER_RELOAD = TW'(STEP_CYCLES - 1);
  localparam logic [ICW-1:0] LAST_ITER    = ICW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] c_r;
  logic [WIDTH-1:0] d_r;
  logic             busy_r;
  logic             done_r;
  logic [1:0]       step_r;
  logic [ICW-1:0]   iter_r;
  logic [TW-1:0]    timer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      c_r    <= '0;
      d_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      step_r <= 2'd0;
      iter_r <= '0;
      timer  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r    <= bus.init_a;
            b_r    <= bus.init_b;
            c_r    <= bus.init_c;
            d_r    <= bus.init_d;
            step_r <= 2'd0;
            iter_r <= '0;
            timer  <= TIMER_RELOAD;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          // abort beats any update due on the same edge; step/iter stay for debug
          if (bus.abort) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else if (timer != '0) begin
            timer <= timer - TW'(1);
          end else begin
            timer  <= TIMER_RELOAD;
            step_r <= step_r + 2'd1;
            case (step_r)
              2'd0: a_r <= b_r + c_r;
              2'd1: d_r <= a_r - WIDTH'(3);
              2'd2: b_r <= d_r + WIDTH'(10);
              2'd3: c_r <= c_r + WIDTH'(1);
            endcase
            if (step_r == 2'd3) begin
              iter_r <= iter_r + ICW'(1);
              if (iter_r == LAST_ITER) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
                state  <= DONE;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.a        = a_r;
  assign bus.b        = b_r;
  assign bus.c        = c_r;
  assign bus.d        = d_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.step     = step_r;
  assign bus.iter_cnt = iter_r;
endmodule

// File: tb/tb_blocking_seq_ctrl.sv
// Directed bench for blocking_seq_ctrl: three parameter sets checked against an
// edge-count model every cycle, plus hand-computed expectations.
module tb_blocking_seq_ctrl;
  logic clk;
  logic rst;

  logic        st[3];
  logic        ab[3];
  logic [31:0] ia[3];
  logic [31:0] ib[3];
  logic [31:0] ic[3];
  logic [31:0] id[3];

  logic [31:0] oa[3];
  logic [31:0] ob[3];
  logic [31:0] oc[3];
  logic [31:0] od[3];
  logic        obusy[3];
  logic        odone[3];
  logic [31:0] ostep[3];
  logic [31:0] oiter[3];

  int total = 0;
  int bad   = 0;

  blocking_seq_ctrl_if #(.WIDTH(32), .ITER(4)) bus0 ();
  blocking_seq_ctrl_if #(.WIDTH(32), .ITER(1)) bus1 ();
  blocking_seq_ctrl_if #(.WIDTH(32), .ITER(4)) bus2 ();

  blocking_seq_ctrl #(.WIDTH(32), .ITER(4), .STEP_CYCLES(5)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  blocking_seq_ctrl #(.WIDTH(32), .ITER(1), .STEP_CYCLES(5)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  blocking_seq_ctrl #(.WIDTH(32), .ITER(4), .STEP_CYCLES(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.start = st[0];
  assign bus0.abort = ab[0];
  assign bus0.init_a = ia[0];
  assign bus0.init_b = ib[0];
  assign bus0.init_c = ic[0];
  assign bus0.init_d = id[0];
  assign bus1.start = st[1];
  assign bus1.abort = ab[1];
  assign bus1.init_a = ia[1];
  assign bus1.init_b = ib[1];
  assign bus1.init_c = ic[1];
  assign bus1.init_d = id[1];
  assign bus2.start = st[2];
  assign bus2.abort = ab[2];
  assign bus2.init_a = ia[2];
  assign bus2.init_b = ib[2];
  assign bus2.init_c = ic[2];
  assign bus2.init_d = id[2];

  assign oa[0] = bus0.a;
  assign ob[0] = bus0.b;
  assign oc[0] = bus0.c;
  assign od[0] = bus0.d;
  assign obusy[0] = bus0.busy;
  assign odone[0] = bus0.done;
  assign ostep[0] = 32'(bus0.step);
  assign oiter[0] = 32'(bus0.iter_cnt);
  assign oa[1] = bus1.a;
  assign ob[1] = bus1.b;
  assign oc[1] = bus1.c;
  assign od[1] = bus1.d;
  assign obusy[1] = bus1.busy;
  assign odone[1] = bus1.done;
  assign ostep[1] = 32'(bus1.step);
  assign oiter[1] = 32'(bus1.iter_cnt);
  assign oa[2] = bus2.a;
  assign ob[2] = bus2.b;
  assign oc[2] = bus2.c;
  assign od[2] = bus2.d;
  assign obusy[2] = bus2.busy;
  assign odone[2] = bus2.done;
  assign ostep[2] = 32'(bus2.step);
  assign oiter[2] = 32'(bus2.iter_cnt);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an accepted start begins counting edges; every STEP_CYCLES-th edge is
  // update number idx, whose step is idx%4 and whose completed-iteration count is (idx+1)/4.
  int          mMode[3];
  int          mK[3];
  logic [31:0] ma[3];
  logic [31:0] mb[3];
  logic [31:0] mc[3];
  logic [31:0] md[3];
  int          mStep[3];
  int          mIt[3];
  bit          modelReady = 1'b0;

  function automatic int iterOf(int i);
    return (i == 1) ? 1 : 4;
  endfunction

  function automatic int stepCyclesOf(int i);
    return (i == 2) ? 1 : 5;
  endfunction

  task automatic modelEdge(int i);
    int idx;
    if (rst) begin
      mMode[i] = 0;
      mK[i] = 0;
      ma[i] = 0;
      mb[i] = 0;
      mc[i] = 0;
      md[i] = 0;
      mStep[i] = 0;
      mIt[i] = 0;
    end else if (mMode[i] == 0) begin
      if (st[i]) begin
        ma[i] = ia[i];
        mb[i] = ib[i];
        mc[i] = ic[i];
        md[i] = id[i];
        mStep[i] = 0;
        mIt[i] = 0;
        mK[i] = 0;
        mMode[i] = 1;
      end
    end else if (mMode[i] == 1) begin
      if (ab[i]) begin
        mMode[i] = 0;
      end else begin
        mK[i] = mK[i] + 1;
        if (mK[i] % stepCyclesOf(i) == 0) begin
          idx = mK[i] / stepCyclesOf(i) - 1;
          case (idx % 4)
            0: ma[i] = mb[i] + mc[i];
            1: md[i] = ma[i] - 32'd3;
            2: mb[i] = md[i] + 32'd10;
            default: mc[i] = mc[i] + 32'd1;
          endcase
          mStep[i] = (idx + 1) % 4;
          mIt[i] = (idx + 1) / 4;
          if (idx + 1 == 4 * iterOf(i)) mMode[i] = 2;
        end
      end
    end else begin
      mMode[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    if (rst) modelReady = 1'b1;
    for (int i = 0; i < 3; i++) modelEdge(i);
  end

  // Compare every DUT against the model on the falling edge, once reset has been seen.
  always @(negedge clk) begin
    if (modelReady) begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (oa[i] !== ma[i] || ob[i] !== mb[i] || oc[i] !== mc[i] || od[i] !== md[i] ||
            obusy[i] !== (mMode[i] == 1) || odone[i] !== (mMode[i] == 2) ||
            ostep[i] !== 32'(mStep[i]) || oiter[i] !== 32'(mIt[i])) begin
          bad++;
          $display("[TB] FAIL model_cmp dut%0d t=%0t got a=%h b=%h c=%h d=%h busy=%b done=%b step=%0d iter=%0d want a=%h b=%h c=%h d=%h busy=%b done=%b step=%0d iter=%0d",
                   i, $time, oa[i], ob[i], oc[i], od[i], obusy[i], odone[i], ostep[i], oiter[i],
                   ma[i], mb[i], mc[i], md[i], mMode[i] == 1, mMode[i] == 2, mStep[i], mIt[i]);
        end
      end
    end
  end

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, actual, expected);
    end
  endtask

  // Drive inits and start before an edge E; returns just after E.
  task automatic applyStimulus(int i, logic [31:0] va, logic [31:0] vb, logic [31:0] vc,
                               logic [31:0] vd, bit hold);
    @(negedge clk);
    ia[i] = va;
    ib[i] = vb;
    ic[i] = vc;
    id[i] = vd;
    st[i] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) st[i] = 1'b0;
  endtask

  task automatic waitEdges(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      ab[i] = 1'b0;
      ia[i] = '0;
      ib[i] = '0;
      ic[i] = '0;
      id[i] = '0;
    end
    waitEdges(2);
    checkOutput("reset_a", oa[0], 32'd0);
    checkOutput("reset_d", od[0], 32'd0);
    checkOutput("reset_busy", 32'(obusy[0]), 32'd0);
    checkOutput("reset_iter", oiter[0], 32'd0);
    rst = 1'b0;

    $display("[TB] default run");
    applyStimulus(0, 32'd30, 32'd20, 32'd15, 32'd5, 1'b0);
    waitEdges(4);
    checkOutput("t1_before_first_a", oa[0], 32'd30);
    waitEdges(1);
    checkOutput("t1_first_a", oa[0], 32'd35);
    waitEdges(15);
    checkOutput("t1_it1_d", od[0], 32'd32);
    checkOutput("t1_it1_b", ob[0], 32'd42);
    checkOutput("t1_it1_c", oc[0], 32'd16);
    checkOutput("t1_it1_iter", oiter[0], 32'd1);
    waitEdges(60);
    checkOutput("t1_done", 32'(odone[0]), 32'd1);
    checkOutput("t1_busy_in_done", 32'(obusy[0]), 32'd0);
    checkOutput("t1_final_a", oa[0], 32'd107);
    checkOutput("t1_final_b", ob[0], 32'd114);
    checkOutput("t1_final_c", oc[0], 32'd19);
    checkOutput("t1_final_d", od[0], 32'd104);
    checkOutput("t1_final_iter", oiter[0], 32'd4);
    waitEdges(1);
    checkOutput("t1_done_drops", 32'(odone[0]), 32'd0);

    $display("[TB] wrap run");
    applyStimulus(1, 32'd0, 32'd0, 32'd1, 32'd0, 1'b0);
    waitEdges(20);
    checkOutput("t2_done", 32'(odone[1]), 32'd1);
    checkOutput("t2_a", oa[1], 32'd1);
    checkOutput("t2_d", od[1], 32'hFFFF_FFFE);
    checkOutput("t2_b", ob[1], 32'd8);
    checkOutput("t2_c", oc[1], 32'd2);
    waitEdges(1);

    $display("[TB] single-cycle steps");
    applyStimulus(2, 32'd30, 32'd20, 32'd15, 32'd5, 1'b0);
    waitEdges(15);
    checkOutput("t3_b_at15", ob[2], 32'd114);
    checkOutput("t3_c_at15", oc[2], 32'd18);
    checkOutput("t3_busy_at15", 32'(obusy[2]), 32'd1);
    waitEdges(1);
    checkOutput("t3_done", 32'(odone[2]), 32'd1);
    checkOutput("t3_c", oc[2], 32'd19);
    checkOutput("t3_a", oa[2], 32'd107);

    $display("[TB] start held high");
    applyStimulus(0, 32'd30, 32'd20, 32'd15, 32'd5, 1'b1);
    waitEdges(80);
    checkOutput("t4_done", 32'(odone[0]), 32'd1);
    ia[0] = 32'd1;
    ib[0] = 32'd2;
    ic[0] = 32'd3;
    id[0] = 32'd4;
    waitEdges(1);
    checkOutput("t4_not_reloaded", oa[0], 32'd107);
    checkOutput("t4_idle_busy", 32'(obusy[0]), 32'd0);
    waitEdges(1);
    checkOutput("t4_busy_again", 32'(obusy[0]), 32'd1);
    checkOutput("t4_reload_a", oa[0], 32'd1);
    checkOutput("t4_reload_d", od[0], 32'd4);
    st[0] = 1'b0;
    ab[0] = 1'b1;
    waitEdges(1);
    ab[0] = 1'b0;
    checkOutput("t4_abort_busy", 32'(obusy[0]), 32'd0);

    $display("[TB] abort mid-run");
    applyStimulus(0, 32'd30, 32'd20, 32'd15, 32'd5, 1'b0);
    waitEdges(29);
    ab[0] = 1'b1;
    waitEdges(1);
    ab[0] = 1'b0;
    checkOutput("t5_d_held", od[0], 32'd32);
    checkOutput("t5_a", oa[0], 32'd58);
    checkOutput("t5_iter", oiter[0], 32'd1);
    checkOutput("t5_step", ostep[0], 32'd1);
    checkOutput("t5_busy", 32'(obusy[0]), 32'd0);
    waitEdges(3);
    checkOutput("t5_no_done", 32'(odone[0]), 32'd0);

    $display("[TB] abort on final update");
    applyStimulus(1, 32'd0, 32'd0, 32'd1, 32'd0, 1'b0);
    waitEdges(19);
    ab[1] = 1'b1;
    waitEdges(1);
    ab[1] = 1'b0;
    checkOutput("ab_final_c", oc[1], 32'd1);
    checkOutput("ab_final_b", ob[1], 32'd8);
    checkOutput("ab_final_done", 32'(odone[1]), 32'd0);
    waitEdges(2);
    checkOutput("ab_final_no_done", 32'(odone[1]), 32'd0);

    $display("[TB] reset mid-run");
    applyStimulus(0, 32'd30, 32'd20, 32'd15, 32'd5, 1'b0);
    waitEdges(49);
    rst = 1'b1;
    waitEdges(1);
    rst = 1'b0;
    checkOutput("t6_a", oa[0], 32'd0);
    checkOutput("t6_b", ob[0], 32'd0);
    checkOutput("t6_iter", oiter[0], 32'd0);
    checkOutput("t6_step", ostep[0], 32'd0);
    checkOutput("t6_busy", 32'(obusy[0]), 32'd0);
    applyStimulus(0, 32'd30, 32'd20, 32'd15, 32'd5, 1'b0);
    waitEdges(80);
    checkOutput("t6_rerun_done", 32'(odone[0]), 32'd1);
    checkOutput("t6_rerun_a", oa[0], 32'd107);
    checkOutput("t6_rerun_d", od[0], 32'd104);
    waitEdges(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
